// File: rtl/regfile_wb_scoreboard.sv
// Register-file writeback arbiter with RAW/WAW scoreboard and long-latency throttle.
// Latency: selected write reaches rf_* one cycle later; stall is combinational.
// Backpressure: stall holds decode; lu_ready drops while the 2-entry long-unit FIFO is full.
//
// Ports:
//   clock, reset                        system clock, synchronous active-high reset
//   issue_* / stall                     decode handshake, stall means "not accepted"
//   wb_valid/wb_addr/wb_data            in-order writeback, always wins the write port
//   lu_valid/lu_addr/lu_data, lu_ready  long-latency writeback into a 2-entry FIFO
//   rf_we/rf_waddr/rf_wdata             registered register-file write port
//   long_outstanding                    accepted long ops not yet popped (0..4)

// Small synchronous FIFO, two entries. Caller never pushes when full or pops when empty.
// Latency: head is valid the cycle after a push into an empty FIFO.
// Backpressure: level is exposed so the owner derives ready/empty itself.
module sync_fifo2 #(
   parameter int W = 37
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic [1:0]   level
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         level  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   level <= level + 2'd1;
            2'b01:   level <= level - 2'd1;
            default: level <= level;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module regfile_wb_scoreboard (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rs,
   input  logic [4:0]  issue_rt,
   input  logic        issue_use_rs,
   input  logic        issue_use_rt,
   input  logic [4:0]  issue_dest,
   input  logic        issue_long,
   output logic        stall,
   input  logic        wb_valid,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [2:0]  long_outstanding
);
   typedef enum logic {NORMAL = 1'b0, THROTTLE = 1'b1} state_t;

   state_t      state;
   logic [31:0] pend;
   logic [2:0]  starve_cnt;

   logic [1:0]  fifo_level;
   logic [1:0]  fifo_level_next;
   logic [36:0] fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;

   logic        sel_vld;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;
   logic        throttle;
   logic        accept;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   sync_fifo2 #(.W(37)) u_lu_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .push_dat ({lu_addr, lu_data}),
      .pop      (pop),
      .head_dat (fifo_head),
      .level    (fifo_level)
   );

   assign fifo_full       = (fifo_level == 2'd2);
   assign fifo_empty      = (fifo_level == 2'd0);
   assign lu_ready        = ~fifo_full;
   assign push            = lu_valid & lu_ready;
   assign pop             = ~wb_valid & ~fifo_empty;
   assign fifo_level_next = fifo_level + {1'b0, push} - {1'b0, pop};

   // Fixed priority: in-order writeback first, FIFO head otherwise.
   always_comb begin
      sel_vld  = 1'b0;
      sel_addr = 5'd0;
      sel_data = 32'd0;
      if (wb_valid) begin
         sel_vld  = 1'b1;
         sel_addr = wb_addr;
         sel_data = wb_data;
      end else if (pop) begin
         sel_vld  = 1'b1;
         sel_addr = fifo_head[36:32];
         sel_data = fifo_head[31:0];
      end
   end

   // The counter raises throttle in the same cycle it saturates; the FSM keeps
   // it raised until the FIFO has drained.
   assign throttle = (starve_cnt == 3'd4) | (state == THROTTLE);

   // Hazards use the pre-edge bitmap, so a register being written this cycle still stalls.
   assign stall = issue_valid & ((issue_use_rs & pend[issue_rs]) |
                                 (issue_use_rt & pend[issue_rt]) |
                                 ((issue_dest != 5'd0) & pend[issue_dest]) |
                                 (issue_long & (long_outstanding == 3'd4)) |
                                 throttle);
   assign accept = issue_valid & ~stall;

   assign set_mask = (accept && issue_dest != 5'd0) ? (32'd1 << issue_dest) : 32'd0;
   assign clr_mask = (sel_vld && sel_addr != 5'd0) ? (32'd1 << sel_addr) : 32'd0;

   always_ff @(posedge clock) begin
      if (reset) begin
         pend             <= 32'd0;
         long_outstanding <= 3'd0;
         starve_cnt       <= 3'd0;
         state            <= NORMAL;
         rf_we            <= 1'b0;
         rf_waddr         <= 5'd0;
         rf_wdata         <= 32'd0;
      end else begin
         // A new producer of the same register wins over a clear on the same edge.
         pend <= ((pend & ~clr_mask) | set_mask) & ~32'd1;

         rf_we    <= sel_vld & (sel_addr != 5'd0);
         rf_waddr <= sel_addr;
         rf_wdata <= sel_data;

         case ({accept & issue_long, pop})
            2'b10:   long_outstanding <= long_outstanding + 3'd1;
            2'b01:   long_outstanding <= (long_outstanding != 3'd0) ? long_outstanding - 3'd1
                                                                   : long_outstanding;
            default: long_outstanding <= long_outstanding;
         endcase

         if (pop)
            starve_cnt <= 3'd0;
         else if (fifo_full && wb_valid)
            starve_cnt <= (starve_cnt == 3'd4) ? starve_cnt : starve_cnt + 3'd1;
         else
            starve_cnt <= 3'd0;

         if (state == NORMAL) begin
            if (starve_cnt == 3'd4) state <= THROTTLE;
         end else begin
            if (fifo_level_next == 2'd0) state <= NORMAL;
         end
      end
   end
endmodule
